cdc_req_sender: RTL and testbench

Source-side transmitter for the toggle-handshake clock-domain crossing that carries operand requests (in_a, in_b, mode) to the add/multiply receiver. It buffers incoming requests in a small FIFO, presents one request at a time on a held-stable data bus, announces each request by flipping a single toggle line, and waits for the receiver's returned acknowledge toggle, synchronized internally, before launching the next request. It is the sending end of the same request/acknowledge toggle protocol the receiver already implements, and runs entirely in the sender's clock domain.

---
 rtl/cdc_req_sender_if.sv | 26 ++
 rtl/cdc_req_sender.sv | 149 ++++++++++++++
 tb/tb_cdc_req_sender.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cdc_req_sender_if.sv
// Request-side bus of the toggle-handshake crossing: source FIFO input plus
// the held data / request toggle / returned acknowledge toggle.
interface cdc_req_sender_if;
    localparam int unsigned OP_W = 4;

    logic            in_valid;
    logic [OP_W-1:0] in_a;
    logic [OP_W-1:0] in_b;
    logic            mode;
    logic            in_ready;
    logic            ack_tgl;
    logic            req_tgl;
    logic [OP_W-1:0] tx_a;
    logic [OP_W-1:0] tx_b;
    logic            tx_mode;

    modport master (
        input  in_valid, in_a, in_b, mode, ack_tgl,
        output in_ready, req_tgl, tx_a, tx_b, tx_mode
    );

    modport slave (
        output in_valid, in_a, in_b, mode, ack_tgl,
        input  in_ready, req_tgl, tx_a, tx_b, tx_mode
    );
endinterface

// File: rtl/cdc_req_sender.sv
// Sending end of the toggle-handshake CDC: queues operand requests, holds one
// on tx_*, flips req_tgl, and waits for the synchronized ack toggle.
module cdc_req_sender #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cdc_req_sender_if.master       bus,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic                   proto_err,
    output logic [$clog2(DEPTH):0] fifo_cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OP_W  = 4;

    typedef struct packed {
        logic            mode;
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } req_t;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;

    req_t                   r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [CNT_W-1:0]       r_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    state_t                 r_state;
    logic                   r_req_tgl;
    req_t                   r_tx;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_ovf;
    logic                   r_perr;

    state_t w_state_nxt;
    logic   w_in_ready;
    logic   w_push;
    logic   w_pop;
    logic   w_flip;
    logic   w_done_nxt;
    logic   w_perr_set;
    logic   w_ack_evt;

    assign w_in_ready = (r_cnt < CNT_W'(DEPTH));
    assign w_push     = bus.in_valid & w_in_ready;
    assign w_ack_evt  = r_sync[SYNC_STAGES-1] ^ r_hist;

    // Handshake FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_flip      = 1'b0;
        w_done_nxt  = 1'b0;
        w_perr_set  = w_ack_evt & (r_state != WAIT_ACK);
        case (r_state)
            IDLE: begin
                if (r_cnt != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                w_flip      = 1'b1;
                w_state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (w_ack_evt) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request FIFO; a same-edge pop never makes room for the push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= '{mode: bus.mode, a: bus.in_a, b: bus.in_b};
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Ack toggle synchronizer plus history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.ack_tgl};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    // Held data bus, request toggle and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx      <= '0;
            r_req_tgl <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            if (w_pop)  r_tx      <= r_mem[r_rptr];
            if (w_flip) r_req_tgl <= ~r_req_tgl;
            r_busy <= (w_state_nxt != IDLE);
            r_done <= w_done_nxt;
            if (bus.in_valid && !w_in_ready) r_ovf  <= 1'b1;
            if (w_perr_set)                  r_perr <= 1'b1;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.req_tgl  = r_req_tgl;
    assign bus.tx_a     = r_tx.a;
    assign bus.tx_b     = r_tx.b;
    assign bus.tx_mode  = r_tx.mode;
    assign busy         = r_busy;
    assign done         = r_done;
    assign overflow     = r_ovf;
    assign proto_err    = r_perr;
    assign fifo_cnt     = r_cnt;
endmodule

// File: tb/tb_cdc_req_sender.sv
// Directed bench for cdc_req_sender: single request, burst, overflow,
// spurious acknowledge and mid-transaction reset.
module tb_cdc_req_sender;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic       done;
    logic       overflow;
    logic       proto_err;
    logic [2:0] fifo_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cdc_req_sender_if bus ();

    cdc_req_sender #(.DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .proto_err (proto_err),
        .fifo_cnt  (fifo_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] ba [4];
        logic [3:0] bb [4];
        logic       bm [4];
        logic       prev_req;
        int         flips;
        int         n_done;
        int         ack_at;
        int         k;

        ba = '{4'd1, 4'd15, 4'd7, 4'd4};
        bb = '{4'd2, 4'd15, 4'd0, 4'd4};
        bm = '{1'b0, 1'b1, 1'b1, 1'b0};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.mode     = 1'b0;
        bus.ack_tgl  = 1'b0;
        step();
        step();
        chk("rst_req_tgl", 32'(bus.req_tgl), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_proto_err", 32'(proto_err), 0);
        chk("rst_fifo_cnt", 32'(fifo_cnt), 0);
        chk("rst_tx_a", 32'(bus.tx_a), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        #2 rst_n = 1'b1;
        step();

        // Single request
        bus.in_valid = 1'b1; bus.in_a = 4'd3; bus.in_b = 4'd5; bus.mode = 1'b0;
        step();                                   // edge 0
        bus.in_valid = 1'b0;
        chk("s_cnt_e0", 32'(fifo_cnt), 1);
        chk("s_busy_e0", 32'(busy), 0);
        step();                                   // edge 1
        chk("s_tx_a_e1", 32'(bus.tx_a), 3);
        chk("s_tx_b_e1", 32'(bus.tx_b), 5);
        chk("s_busy_e1", 32'(busy), 1);
        chk("s_cnt_e1", 32'(fifo_cnt), 0);
        chk("s_req_e1", 32'(bus.req_tgl), 0);
        step();                                   // edge 2
        chk("s_req_e2", 32'(bus.req_tgl), 1);
        step(); step(); step();                   // edges 3..5
        bus.ack_tgl = 1'b1;
        step();                                   // edge 6
        step();                                   // edge 7
        chk("s_done_e7", 32'(done), 0);
        chk("s_busy_e7", 32'(busy), 1);
        step();                                   // edge 8
        chk("s_done_e8", 32'(done), 1);
        chk("s_busy_e8", 32'(busy), 0);
        step();                                   // edge 9
        chk("s_done_e9", 32'(done), 0);
        chk("s_busy_e9", 32'(busy), 0);

        // Burst of four; each flip acknowledged three edges later
        flips = 0;
        for (int e = 0; e < 30; e++) begin
            bus.in_valid = (e < 4);
            if (e < 4) begin
                bus.in_a = ba[e]; bus.in_b = bb[e]; bus.mode = bm[e];
            end
            if (e == 5 || e == 12 || e == 19 || e == 26) bus.ack_tgl = ~bus.ack_tgl;
            prev_req = bus.req_tgl;
            step();
            if (bus.req_tgl != prev_req) flips++;
            if (e == 1 || e == 8 || e == 15 || e == 22) begin
                k = (e - 1) / 7;
                chk("b_tx_a", 32'(bus.tx_a), 32'(ba[k]));
                chk("b_tx_b", 32'(bus.tx_b), 32'(bb[k]));
                chk("b_tx_mode", 32'(bus.tx_mode), 32'(bm[k]));
            end
            if (e == 3) chk("b_cnt_peak", 32'(fifo_cnt), 3);
            if (e == 7 || e == 14 || e == 21 || e == 28) chk("b_done", 32'(done), 1);
        end
        bus.in_valid = 1'b0;
        chk("b_flips", 32'(flips), 4);
        chk("b_overflow", 32'(overflow), 0);
        chk("b_req_final", 32'(bus.req_tgl), 1);

        // Overflow: acks held off while six requests arrive
        for (int e = 0; e < 6; e++) begin
            bus.in_valid = 1'b1;
            bus.in_a = 4'(e + 1); bus.in_b = 4'(e + 1); bus.mode = 1'(e);
            step();
            if (e == 4) begin
                chk("o_cnt_full", 32'(fifo_cnt), 4);
                chk("o_in_ready", 32'(bus.in_ready), 0);
                chk("o_ovf_pre", 32'(overflow), 0);
            end
        end
        bus.in_valid = 1'b0;
        chk("o_ovf_set", 32'(overflow), 1);
        chk("o_cnt_after", 32'(fifo_cnt), 4);
        n_done = 0;
        ack_at = 0;
        for (int it = 0; it < 60; it++) begin
            if (it == ack_at) bus.ack_tgl = ~bus.ack_tgl;
            prev_req = bus.req_tgl;
            step();
            if (done) begin
                n_done++;
                chk("o_order", 32'(bus.tx_a), 32'(n_done));
            end
            if (bus.req_tgl != prev_req) ack_at = it + 3;
        end
        chk("o_delivered", 32'(n_done), 5);
        chk("o_cnt_empty", 32'(fifo_cnt), 0);
        chk("o_busy_idle", 32'(busy), 0);

        // Spurious acknowledge while idle
        bus.ack_tgl = ~bus.ack_tgl;
        step();
        step();
        chk("p_perr_early", 32'(proto_err), 0);
        step();
        chk("p_perr_set", 32'(proto_err), 1);
        chk("p_busy", 32'(busy), 0);
        chk("p_done", 32'(done), 0);
        step();
        chk("p_done_late", 32'(done), 0);
        chk("p_perr_sticky", 32'(proto_err), 1);

        // Reset while waiting for an acknowledge with two queued
        for (int e = 0; e < 3; e++) begin
            bus.in_valid = 1'b1;
            bus.in_a = 4'(e + 10); bus.in_b = 4'd2; bus.mode = 1'b0;
            step();
        end
        bus.in_valid = 1'b0;
        chk("r_cnt_pre", 32'(fifo_cnt), 2);
        chk("r_req_pre", 32'(bus.req_tgl), 1);
        #2;
        rst_n       = 1'b0;
        bus.ack_tgl = 1'b0;
        #1;
        chk("r_req_tgl", 32'(bus.req_tgl), 0);
        chk("r_busy", 32'(busy), 0);
        chk("r_cnt", 32'(fifo_cnt), 0);
        chk("r_overflow", 32'(overflow), 0);
        chk("r_proto_err", 32'(proto_err), 0);
        chk("r_tx_a", 32'(bus.tx_a), 0);
        chk("r_done", 32'(done), 0);
        #1 rst_n = 1'b1;
        step();

        bus.in_valid = 1'b1; bus.in_a = 4'd9; bus.in_b = 4'd6; bus.mode = 1'b1;
        step();                                   // edge 0
        bus.in_valid = 1'b0;
        step();                                   // edge 1
        chk("n_tx_a", 32'(bus.tx_a), 9);
        chk("n_tx_mode", 32'(bus.tx_mode), 1);
        chk("n_req_e1", 32'(bus.req_tgl), 0);
        step();                                   // edge 2
        chk("n_req_e2", 32'(bus.req_tgl), 1);
        step(); step();                           // edges 3, 4
        bus.ack_tgl = 1'b1;
        step(); step();                           // edges 5, 6
        step();                                   // edge 7
        chk("n_done", 32'(done), 1);
        chk("n_busy", 32'(busy), 0);
        chk("n_proto_err", 32'(proto_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
